rtm_sequencer: RTL and testbench

Instruction-driven controller for the 4×4-bit register-transfer datapath: four registers, A/B read muxes, 4-bit adder with carry, and D-bus mux selecting input data or adder sum. It accepts 13-bit micro-instructions over a valid/ready handshake and drives every datapath control line, replacing the manual control switches. It also holds the carry flag between instructions and sequences the multi-cycle repeated-add operation.

---
 rtl/rtm_sequencer_if.sv | 11 +
 rtl/rtm_sequencer.sv | 163 ++++++++++++++++
 tb/tb_rtm_sequencer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/rtm_sequencer_if.sv
// Instruction handshake between an issuing agent and the rtm_sequencer.
interface rtm_sequencer_if;
  localparam int unsigned INSTR_W = 13;

  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;

  modport master (output instr_valid, output instr, input instr_ready);
  modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/rtm_sequencer.sv
// Micro-instruction sequencer driving the 4x4-bit register-transfer datapath.
module rtm_sequencer (
  input  logic                 clock,
  input  logic                 clear_n,
  rtm_sequencer_if.slave       bus,
  input  logic                 dp_carry_out,
  output logic [1:0]           dp_sel_a,
  output logic [1:0]           dp_sel_b,
  output logic [1:0]           dp_wr_sel,
  output logic                 dp_wr_en,
  output logic                 dp_add_sel,
  output logic                 dp_carry_in,
  output logic [3:0]           dp_imm,
  output logic                 dp_clear,
  output logic                 carry_flag,
  output logic                 busy,
  output logic                 illegal
);
  localparam int unsigned DATA_W = 4;
  localparam int unsigned SEL_W  = 2;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LDI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_ADC = 3'b011;
  localparam logic [2:0] OP_REP = 3'b100;
  localparam logic [2:0] OP_CLR = 3'b101;

  typedef enum logic [1:0] {IDLE, EXEC, REP} state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   rem_q;
  logic [SEL_W-1:0]    sel_a_q, sel_b_q, wr_sel_q;
  logic                wr_en_q, add_sel_q, carry_in_q, clear_q, carry_q, illegal_q;
  logic [DATA_W-1:0]   imm_q;

  logic                accept;
  logic [2:0]          f_op;
  logic [SEL_W-1:0]    f_dst, f_sa, f_sb;
  logic [DATA_W-1:0]   f_imm;

  // Instruction field split and handshake
  assign {f_op, f_dst, f_sa, f_sb, f_imm} = bus.instr;
  assign bus.instr_ready = clear_n && (state_q == IDLE);
  assign accept          = bus.instr_valid && bus.instr_ready;

  // Sequencer state, carry flag and registered datapath controls
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      sel_a_q    <= '0;
      sel_b_q    <= '0;
      wr_sel_q   <= '0;
      wr_en_q    <= 1'b0;
      add_sel_q  <= 1'b0;
      carry_in_q <= 1'b0;
      imm_q      <= '0;
      clear_q    <= 1'b0;
      carry_q    <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      // Carry follows the adder on every arithmetic write; CLR zeroes it
      if (wr_en_q && add_sel_q) begin
        carry_q <= dp_carry_out;
      end else if (clear_q) begin
        carry_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q    <= EXEC;
            rem_q      <= '0;
            sel_a_q    <= '0;
            sel_b_q    <= '0;
            wr_sel_q   <= '0;
            wr_en_q    <= 1'b0;
            add_sel_q  <= 1'b0;
            carry_in_q <= 1'b0;
            imm_q      <= '0;
            clear_q    <= 1'b0;
            illegal_q  <= 1'b0;
            case (f_op)
              OP_NOP: ;
              OP_LDI: begin
                imm_q    <= f_imm;
                wr_sel_q <= f_dst;
                wr_en_q  <= 1'b1;
              end
              OP_ADD, OP_ADC: begin
                sel_a_q    <= f_sa;
                sel_b_q    <= f_sb;
                add_sel_q  <= 1'b1;
                carry_in_q <= (f_op == OP_ADC) ? carry_q : 1'b0;
                wr_sel_q   <= f_dst;
                wr_en_q    <= 1'b1;
              end
              OP_REP: begin
                // Zero count degenerates to a NOP
                if (f_imm != '0) begin
                  sel_a_q   <= f_sa;
                  sel_b_q   <= f_sb;
                  add_sel_q <= 1'b1;
                  wr_sel_q  <= f_dst;
                  wr_en_q   <= 1'b1;
                  rem_q     <= DATA_W'(f_imm - DATA_W'(1));
                end
              end
              OP_CLR:  clear_q   <= 1'b1;
              default: illegal_q <= 1'b1;
            endcase
          end
        end

        EXEC: begin
          if (rem_q != '0) begin
            // Later iterations accumulate into dst: dst = dst + sb
            state_q <= REP;
            sel_a_q <= wr_sel_q;
          end else begin
            state_q    <= IDLE;
            sel_a_q    <= '0;
            sel_b_q    <= '0;
            wr_sel_q   <= '0;
            wr_en_q    <= 1'b0;
            add_sel_q  <= 1'b0;
            carry_in_q <= 1'b0;
            imm_q      <= '0;
          end
          clear_q   <= 1'b0;
          illegal_q <= 1'b0;
        end

        REP: begin
          rem_q <= DATA_W'(rem_q - DATA_W'(1));
          if (rem_q == DATA_W'(1)) begin
            state_q   <= IDLE;
            sel_a_q   <= '0;
            sel_b_q   <= '0;
            wr_sel_q  <= '0;
            wr_en_q   <= 1'b0;
            add_sel_q <= 1'b0;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign dp_sel_a    = sel_a_q;
  assign dp_sel_b    = sel_b_q;
  assign dp_wr_sel   = wr_sel_q;
  assign dp_wr_en    = wr_en_q;
  assign dp_add_sel  = add_sel_q;
  assign dp_carry_in = carry_in_q;
  assign dp_imm      = imm_q;
  assign dp_clear    = clear_q;
  assign carry_flag  = carry_q;
  assign illegal     = illegal_q;
  assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_rtm_sequencer.sv
// Scoreboard bench: sequencer plus a behavioural 4x4-bit datapath.
module tb_rtm_sequencer;
  logic clock = 1'b0;
  logic clear_n = 1'b0;
  always #5 clock = ~clock;

  rtm_sequencer_if bus ();

  logic [1:0] dp_sel_a, dp_sel_b, dp_wr_sel;
  logic       dp_wr_en, dp_add_sel, dp_carry_in, dp_clear;
  logic [3:0] dp_imm;
  logic       dp_carry_out, carry_flag, busy, illegal;

  rtm_sequencer dut (
    .clock(clock), .clear_n(clear_n), .bus(bus), .dp_carry_out(dp_carry_out),
    .dp_sel_a(dp_sel_a), .dp_sel_b(dp_sel_b), .dp_wr_sel(dp_wr_sel),
    .dp_wr_en(dp_wr_en), .dp_add_sel(dp_add_sel), .dp_carry_in(dp_carry_in),
    .dp_imm(dp_imm), .dp_clear(dp_clear), .carry_flag(carry_flag),
    .busy(busy), .illegal(illegal)
  );

  // Datapath: four registers, adder with carry, D-bus mux
  logic [3:0] rf [4];
  logic [4:0] sum5;
  logic [3:0] dbus;
  always_comb begin
    sum5         = 5'(rf[dp_sel_a]) + 5'(rf[dp_sel_b]) + 5'(dp_carry_in);
    dbus         = dp_add_sel ? sum5[3:0] : dp_imm;
    dp_carry_out = sum5[4];
  end
  always @(posedge clock) begin
    if (!clear_n || dp_clear) begin
      for (int i = 0; i < 4; i++) rf[i] <= 4'd0;
    end else if (dp_wr_en) begin
      rf[dp_wr_sel] <= dbus;
    end
  end

  int tests = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard of expected register writes
  typedef struct packed {logic [1:0] sel; logic [3:0] data;} wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  task automatic exp_wr(input int sel, input int data);
    wr_t e;
    e.sel  = 2'(sel);
    e.data = 4'(data);
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle with a write is matched against the scoreboard
  always @(negedge clock) begin
    if (dp_wr_en) begin
      if (exp_q.size() == 0) begin
        tests++;
        errors++;
        $display("FAIL unexpected_write: got sel=%0d data=%0d, expected no write", dp_wr_sel, dbus);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_sel", int'(dp_wr_sel), int'(mon_e.sel));
        chk("write_data", int'(dbus), int'(mon_e.data));
      end
    end
  end

  function automatic logic [12:0] mk(input int op, input int dst, input int sa, input int sb, input int imm);
    return {3'(op), 2'(dst), 2'(sa), 2'(sb), 4'(imm)};
  endfunction

  // Wait for ready, accept, then check write enable in the cycle after accept
  task automatic issue(input logic [12:0] ins, input logic exp_we, input string name);
    int n = 0;
    @(negedge clock);
    while (!bus.instr_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk({name, "_ready"}, int'(bus.instr_ready), 1);
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    @(posedge clock);
    #1 bus.instr_valid = 1'b0;
    @(negedge clock);
    chk({name, "_wr_en"}, int'(dp_wr_en), int'(exp_we));
  endtask

  // Count busy cycles (starting in the EXEC cycle) and note ready leaks
  task automatic wait_idle(output int cyc, output logic rdy_leak);
    cyc = 0;
    rdy_leak = 1'b0;
    while (busy && cyc < 50) begin
      if (bus.instr_ready) rdy_leak = 1'b1;
      cyc++;
      @(negedge clock);
    end
    if (cyc >= 50) chk("idle_timeout", cyc, 0);
  endtask

  int   cyc;
  logic leak;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    clear_n         = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_ready", int'(bus.instr_ready), 0);
    chk("reset_dp", int'({dp_sel_a, dp_sel_b, dp_wr_sel, dp_wr_en, dp_add_sel,
                          dp_carry_in, dp_imm, dp_clear}), 0);
    chk("reset_flags", int'({carry_flag, busy, illegal}), 0);
    clear_n = 1'b1;

    // LDI, LDI, ADD with carry out
    exp_wr(1, 9);  issue(mk(1, 1, 0, 0, 9), 1'b1, "ldi_r1");
    exp_wr(2, 8);  issue(mk(1, 2, 0, 0, 8), 1'b1, "ldi_r2");
    exp_wr(0, 1);  issue(mk(2, 0, 1, 2, 0), 1'b1, "add");
    wait_idle(cyc, leak);
    chk("add_busy_cycles", cyc, 1);
    chk("add_carry", int'(carry_flag), 1);

    // ADC consumes the stored carry
    exp_wr(3, 2);  issue(mk(1, 3, 0, 0, 2), 1'b1, "ldi_r3");
    wait_idle(cyc, leak);
    chk("ldi_keeps_carry", int'(carry_flag), 1);
    exp_wr(3, 11); issue(mk(3, 3, 3, 2, 0), 1'b1, "adc");
    wait_idle(cyc, leak);
    chk("adc_carry", int'(carry_flag), 0);
    chk("adc_r3", int'(rf[3]), 11);

    // REP imm=5: R0 = 0 + 5*3
    exp_wr(1, 0);  issue(mk(1, 1, 0, 0, 0), 1'b1, "ldi_r1z");
    exp_wr(2, 3);  issue(mk(1, 2, 0, 0, 3), 1'b1, "ldi_r2b");
    exp_wr(0, 3); exp_wr(0, 6); exp_wr(0, 9); exp_wr(0, 12); exp_wr(0, 15);
    issue(mk(4, 0, 1, 2, 5), 1'b1, "rep5");
    wait_idle(cyc, leak);
    chk("rep5_busy_cycles", cyc, 5);
    chk("rep5_ready_low", int'(leak), 0);
    chk("rep5_r0", int'(rf[0]), 15);
    chk("rep5_carry", int'(carry_flag), 0);

    // REP imm=0 is a NOP
    issue(mk(4, 0, 1, 2, 0), 1'b0, "rep0");
    wait_idle(cyc, leak);
    chk("rep0_busy_cycles", cyc, 1);
    chk("rep0_r0", int'(rf[0]), 15);

    // Set carry, then reset during the third REP iteration
    exp_wr(1, 15); issue(mk(1, 1, 0, 0, 15), 1'b1, "ldi_r1f");
    exp_wr(3, 14); issue(mk(2, 3, 1, 1, 0), 1'b1, "add_cy");
    exp_wr(1, 0);  issue(mk(1, 1, 0, 0, 0), 1'b1, "ldi_r1z2");
    chk("pre_rst_carry", int'(carry_flag), 1);
    exp_wr(0, 3); exp_wr(0, 6); exp_wr(0, 9);
    issue(mk(4, 0, 1, 2, 5), 1'b1, "rep_rst");
    @(negedge clock);
    @(negedge clock);
    clear_n = 1'b0;
    @(negedge clock);
    chk("rst_wr_en", int'(dp_wr_en), 0);
    chk("rst_carry", int'(carry_flag), 0);
    chk("rst_ready", int'(bus.instr_ready), 0);
    chk("rst_busy", int'(busy), 0);
    @(negedge clock);
    chk("rst_wr_en_hold", int'(dp_wr_en), 0);
    clear_n = 1'b1;
    @(negedge clock);
    chk("rst_ready_after", int'(bus.instr_ready), 1);
    chk("rst_queue_empty", exp_q.size(), 0);

    // Illegal op then CLR
    exp_wr(1, 15); issue(mk(1, 1, 0, 0, 15), 1'b1, "ldi_r1f2");
    exp_wr(3, 14); issue(mk(2, 3, 1, 1, 0), 1'b1, "add_cy2");
    issue(mk(7, 2, 1, 1, 5), 1'b0, "op111");
    chk("op111_illegal", int'(illegal), 1);
    chk("op111_clear", int'(dp_clear), 0);
    @(negedge clock);
    chk("op111_pulse_end", int'(illegal), 0);
    chk("op111_carry_kept", int'(carry_flag), 1);
    issue(mk(5, 0, 0, 0, 0), 1'b0, "clr");
    chk("clr_pulse", int'(dp_clear), 1);
    @(negedge clock);
    chk("clr_pulse_end", int'(dp_clear), 0);
    chk("clr_carry", int'(carry_flag), 0);
    chk("clr_r1", int'(rf[1]), 0);

    repeat (2) @(negedge clock);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
